// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches from the instruction cache over a read/busywait
// handshake and fills the IF/ID register, with a one-entry hold buffer and redirect drain.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_readdata,
   input  logic        imem_busywait,
   input  logic        stall,
   input  logic        branch_jump_taken,
   input  logic [31:0] branch_jump_target,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus_4,
   output logic        instr_valid,
   output logic        fetch_busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] drain_target;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;

   logic [31:0] pc_next;
   logic [31:0] hold_pc_next;
   logic [31:0] target_aligned;

   assign pc_next        = pc + 32'd4;
   assign hold_pc_next   = hold_pc + 32'd4;
   assign target_aligned = branch_jump_target & 32'hFFFF_FFFC;

   // Request side depends only on registers, so the cache sees no input-to-output path.
   assign imem_read    = (state == S_REQ) || (state == S_DRAIN);
   assign imem_address = pc;
   assign fetch_busy   = imem_read & imem_busywait;

   // NOTE: all state here is updated with non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         pc           <= RESET_PC;
         drain_target <= RESET_PC;
         hold_instr   <= NOP_INSTR;
         hold_pc      <= 32'd0;
         instruction  <= NOP_INSTR;
         pc_out       <= 32'd0;
         pc_plus_4    <= 32'd0;
         instr_valid  <= 1'b0;
      end else if (branch_jump_taken) begin
         instruction <= NOP_INSTR;
         instr_valid <= 1'b0;
         // An in-flight miss must complete before the cache will take a new address.
         if (imem_read && imem_busywait) begin
            state        <= S_DRAIN;
            drain_target <= target_aligned;
         end else begin
            state <= S_REQ;
            pc    <= target_aligned;
         end
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (!imem_busywait) begin
                  pc <= pc_next;
                  if (stall) begin
                     hold_instr <= imem_readdata;
                     hold_pc    <= pc;
                     state      <= S_HOLD;
                  end else begin
                     instruction <= imem_readdata;
                     pc_out      <= pc;
                     pc_plus_4   <= pc_next;
                     instr_valid <= 1'b1;
                  end
               end else if (!stall) begin
                  instruction <= NOP_INSTR;
                  instr_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  instruction <= hold_instr;
                  pc_out      <= hold_pc;
                  pc_plus_4   <= hold_pc_next;
                  instr_valid <= 1'b1;
                  state       <= S_REQ;
               end
            end
            S_DRAIN: begin
               // The word returned here belongs to the abandoned path and is dropped.
               if (!imem_busywait) begin
                  pc    <= drain_target;
                  state <= S_REQ;
               end
               if (!stall) begin
                  instruction <= NOP_INSTR;
                  instr_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table for the corner cases, then
// random stimulus checked against a behavioural fetch model.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, imem_busywait, stall, branch_jump_taken;
   logic [31:0] branch_jump_target;

   logic        imem_read, instr_valid, fetch_busy;
   logic [31:0] imem_address, imem_readdata, instruction, pc_out, pc_plus_4;

   logic        imem_read2, instr_valid2, fetch_busy2;
   logic [31:0] imem_address2, imem_readdata2, instruction2, pc_out2, pc_plus_42;

   int n_checks = 0;
   int n_errors = 0;
   int cur_step = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   // Cache returns garbage while busy so a misused word is visible.
   assign imem_readdata  = imem_busywait ? 32'hDEAD_BEEF : word_at(imem_address);
   assign imem_readdata2 = imem_busywait ? 32'hDEAD_BEEF : word_at(imem_address2);

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .imem_read(imem_read), .imem_address(imem_address),
      .imem_readdata(imem_readdata), .imem_busywait(imem_busywait), .stall(stall),
      .branch_jump_taken(branch_jump_taken), .branch_jump_target(branch_jump_target),
      .instruction(instruction), .pc_out(pc_out), .pc_plus_4(pc_plus_4),
      .instr_valid(instr_valid), .fetch_busy(fetch_busy));

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
      .clk(clk), .reset(reset), .imem_read(imem_read2), .imem_address(imem_address2),
      .imem_readdata(imem_readdata2), .imem_busywait(imem_busywait), .stall(stall),
      .branch_jump_taken(branch_jump_taken), .branch_jump_target(branch_jump_target),
      .instruction(instruction2), .pc_out(pc_out2), .pc_plus_4(pc_plus_42),
      .instr_valid(instr_valid2), .fetch_busy(fetch_busy2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, cur_step, act, exp);
      end
   endtask

   // Pre-edge request outputs captured just after inputs are driven on the falling edge.
   logic        p_read, p_busy;
   logic [31:0] p_addr, p_addr2;

   task automatic cycle(input logic r, input logic b, input logic s, input logic j,
                        input logic [31:0] t);
      @(negedge clk);
      reset = r; imem_busywait = b; stall = s; branch_jump_taken = j; branch_jump_target = t;
      #1;
      p_read = imem_read; p_addr = imem_address; p_busy = fetch_busy; p_addr2 = imem_address2;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst, bw, st, br;
      logic [31:0] tgt;
      logic        chk_pre;
      logic        e_read;
      logic [31:0] e_addr;
      logic        e_busy;
      logic [31:0] e_instr, e_pc, e_pc4;
      logic        e_valid;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rst, bw, st, br, input logic [31:0] tgt,
                               input logic chk_pre, e_read, input logic [31:0] e_addr,
                               input logic e_busy, input logic [31:0] e_instr, e_pc, e_pc4,
                               input logic e_valid);
      vec_t v;
      v.rst = rst; v.bw = bw; v.st = st; v.br = br; v.tgt = tgt;
      v.chk_pre = chk_pre; v.e_read = e_read; v.e_addr = e_addr; v.e_busy = e_busy;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_valid = e_valid;
      return v;
   endfunction

   // Behavioural model: where the next fetch goes, whether a word is parked,
   // whether a redirected miss is being drained, and what IF/ID shows.
   logic [31:0] m_pc, m_tgt, m_hold_w, m_hold_pc, m_instr, m_pcout, m_pc4;
   logic        m_idle, m_hold, m_drain, m_valid;

   task automatic model_edge(input logic r, input logic b, input logic s, input logic j,
                             input logic [31:0] t);
      logic reading;
      reading = !m_idle && !m_hold;
      if (r) begin
         m_pc = 32'h0; m_idle = 1'b1; m_hold = 1'b0; m_drain = 1'b0;
         m_instr = NOP; m_pcout = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (j) begin
         m_instr = NOP; m_valid = 1'b0; m_hold = 1'b0;
         if (reading && b) begin
            m_drain = 1'b1; m_tgt = t & 32'hFFFF_FFFC;
         end else begin
            m_pc = t & 32'hFFFF_FFFC; m_drain = 1'b0; m_idle = 1'b0;
         end
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else if (m_hold) begin
         if (!s) begin
            m_instr = m_hold_w; m_pcout = m_hold_pc; m_pc4 = m_hold_pc + 32'd4;
            m_valid = 1'b1; m_hold = 1'b0;
         end
      end else if (m_drain) begin
         if (!s) begin m_instr = NOP; m_valid = 1'b0; end
         if (!b) begin m_pc = m_tgt; m_drain = 1'b0; end
      end else if (!b) begin
         if (s) begin
            m_hold = 1'b1; m_hold_w = word_at(m_pc); m_hold_pc = m_pc;
         end else begin
            m_instr = word_at(m_pc); m_pcout = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!s) begin
         m_instr = NOP; m_valid = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] w0, w4, w8, wc, w10, w14, w100, w400, w80;
      reset = 1'b1; imem_busywait = 1'b0; stall = 1'b0;
      branch_jump_taken = 1'b0; branch_jump_target = 32'h0;
      w0 = word_at(32'h0); w4 = word_at(32'h4); w8 = word_at(32'h8); wc = word_at(32'hC);
      w10 = word_at(32'h10); w14 = word_at(32'h14); w100 = word_at(32'h100);
      w400 = word_at(32'h400); w80 = word_at(32'h80);

      //              rst bw st br tgt          pre rd addr         bsy instr pc       pc4      v
      vq.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, NOP,  32'h0,   32'h0,   0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, NOP,  32'h0,   32'h0,   0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h0,   0, w0,   32'h0,   32'h4,   1));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h4,   0, w4,   32'h4,   32'h8,   1));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h8,   0, w8,   32'h8,   32'hC,   1));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'hC,   1, NOP,  32'h8,   32'hC,   0));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'hC,   1, NOP,  32'h8,   32'hC,   0));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'hC,   1, NOP,  32'h8,   32'hC,   0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'hC,   0, wc,   32'hC,   32'h10,  1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,   1, 1, 32'h10,  0, wc,   32'hC,   32'h10,  1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,   1, 0, 32'h14,  0, wc,   32'hC,   32'h10,  1));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 32'h14,  0, w10,  32'h10,  32'h14,  1));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h14,  0, w14,  32'h14,  32'h18,  1));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h18,  1, NOP,  32'h14,  32'h18,  0));
      vq.push_back(mk(0, 1, 0, 1, 32'h101, 1, 1, 32'h18,  1, NOP,  32'h14,  32'h18,  0));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h18,  1, NOP,  32'h14,  32'h18,  0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h18,  0, NOP,  32'h14,  32'h18,  0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h100, 0, w100, 32'h100, 32'h104, 1));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h104, 1, NOP,  32'h100, 32'h104, 0));
      vq.push_back(mk(0, 1, 0, 1, 32'h200, 1, 1, 32'h104, 1, NOP,  32'h100, 32'h104, 0));
      vq.push_back(mk(0, 1, 0, 1, 32'h300, 1, 1, 32'h104, 1, NOP,  32'h100, 32'h104, 0));
      vq.push_back(mk(0, 0, 0, 1, 32'h403, 1, 1, 32'h104, 0, NOP,  32'h100, 32'h104, 0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h400, 0, w400, 32'h400, 32'h404, 1));
      vq.push_back(mk(0, 0, 1, 0, 32'h0,   1, 1, 32'h404, 0, w400, 32'h400, 32'h404, 1));
      vq.push_back(mk(0, 0, 1, 1, 32'h80,  1, 0, 32'h408, 0, NOP,  32'h400, 32'h404, 0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h80,  0, w80,  32'h80,  32'h84,  1));
      vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h84,  1, NOP,  32'h80,  32'h84,  0));
      vq.push_back(mk(1, 1, 0, 0, 32'h0,   1, 1, 32'h84,  1, NOP,  32'h0,   32'h0,   0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, NOP,  32'h0,   32'h0,   0));
      vq.push_back(mk(0, 0, 0, 0, 32'h0,   1, 1, 32'h0,   0, w0,   32'h0,   32'h4,   1));

      foreach (vq[i]) begin
         cur_step = i;
         cycle(vq[i].rst, vq[i].bw, vq[i].st, vq[i].br, vq[i].tgt);
         if (vq[i].chk_pre) begin
            check("imem_read", {31'd0, p_read}, {31'd0, vq[i].e_read});
            check("imem_address", p_addr, vq[i].e_addr);
            check("fetch_busy", {31'd0, p_busy}, {31'd0, vq[i].e_busy});
         end
         check("instruction", instruction, vq[i].e_instr);
         check("pc_out", pc_out, vq[i].e_pc);
         check("pc_plus_4", pc_plus_4, vq[i].e_pc4);
         check("instr_valid", {31'd0, instr_valid}, {31'd0, vq[i].e_valid});
         if (i == 2) begin
            check("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
            check("wrap_pc_plus_4", pc_plus_42, 32'h0);
            check("wrap_instr", instruction2, word_at(32'hFFFF_FFFC));
         end
         if (i == 3) check("wrap_next_addr", p_addr2, 32'h0);
      end

      // Random phase: starts from reset so the model and DUT agree on state.
      for (int n = 0; n < 3000; n++) begin
         logic r, b, s, j, e_read;
         logic [31:0] t, e_addr;
         cur_step = 1000 + n;
         r = (n == 0) || ($urandom_range(0, 59) == 0);
         b = ($urandom_range(0, 9) < 4);
         s = ($urandom_range(0, 9) < 3);
         j = ($urandom_range(0, 9) == 0);
         t = $urandom;
         e_read = !m_idle && !m_hold;
         e_addr = m_pc;
         cycle(r, b, s, j, t);
         if (n != 0) begin
            check("rnd_imem_read", {31'd0, p_read}, {31'd0, e_read});
            check("rnd_imem_address", p_addr, e_addr);
            check("rnd_fetch_busy", {31'd0, p_busy}, {31'd0, e_read & b});
         end
         model_edge(r, b, s, j, t);
         check("rnd_instruction", instruction, m_instr);
         check("rnd_pc_out", pc_out, m_pcout);
         check("rnd_pc_plus_4", pc_plus_4, m_pc4);
         check("rnd_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
